axis_pkt_gen: RTL and testbench

Transmit-side AXI4-Stream packet source that drives the OPED egress slave stream (S_AXIS_DAT plus LEN/SPT/DPT/ERR sideband). A stand-in top-level or bench uses it as the data-plane producer in place of the NetFPGA-10G datapath. Each accepted command emits one packet of CMD_LEN bytes as 256-bit beats carrying a deterministic incrementing-word pattern, so a downstream checker can verify the payload. It also counts completed packets.

---
 rtl/axis_pkt_gen_pkg.sv | 24 ++
 rtl/axis_pkt_gen_if.sv | 27 ++
 rtl/axis_pkt_gen.sv | 145 ++++++++++++++
 tb/tb_axis_pkt_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_gen_pkg.sv
// Shared types, widths and helper functions for the AXI4-Stream packet generator.
package axis_pkt_pkg;

  localparam int DAT_BYTES = 32;
  localparam int DAT_W     = 256;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  // Byte enables of the final beat: a remainder of zero means a full beat.
  function automatic logic [31:0] last_strb(input logic [4:0] rem);
    if (rem == 5'd0) return 32'hFFFF_FFFF;
    return (32'd1 << rem) - 32'd1;
  endfunction

  // Beats needed for a packet of len bytes (ceil(len/32)); at most 2048.
  function automatic logic [11:0] beats(input logic [15:0] len);
    return {1'b0, len[15:5]} + {11'd0, (len[4:0] != 5'd0)};
  endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// Egress stream bundle: 256-bit data stream plus LEN/SPT/DPT/ERR sideband.
interface axis_pkt_gen_if;
  import axis_pkt_pkg::*;

  logic [DAT_W-1:0]     DAT_TDATA;
  logic                 DAT_TVALID;
  logic [DAT_BYTES-1:0] DAT_TSTRB;
  logic                 DAT_TLAST;
  logic                 DAT_TREADY;
  logic [15:0]          LEN_TDATA;
  logic [7:0]           SPT_TDATA;
  logic [7:0]           DPT_TDATA;
  logic                 ERR_TDATA;

  modport master (
    output DAT_TDATA, DAT_TVALID, DAT_TSTRB, DAT_TLAST,
    output LEN_TDATA, SPT_TDATA, DPT_TDATA, ERR_TDATA,
    input  DAT_TREADY
  );

  modport slave (
    input  DAT_TDATA, DAT_TVALID, DAT_TSTRB, DAT_TLAST,
    input  LEN_TDATA, SPT_TDATA, DPT_TDATA, ERR_TDATA,
    output DAT_TREADY
  );

endinterface

// File: rtl/axis_pkt_gen.sv
// Command-driven packet source: one accepted command emits one packet of
// incrementing 32-bit words, followed by an optional inter-frame gap.
module axis_pkt_gen
  import axis_pkt_pkg::*;
#(
  parameter int unsigned IFG = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ENABLE,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [15:0]           CMD_LEN,
  input  logic [7:0]            CMD_SPT,
  input  logic [7:0]            CMD_DPT,
  input  logic                  CMD_ERR,
  input  logic [31:0]           CMD_SEED,
  axis_pkt_gen_if.master        M_AXIS,
  output logic                  BUSY,
  output logic [31:0]           PKT_COUNT
);

  localparam logic [7:0] IFG_CNT = 8'(IFG);

  state_t               state, state_nxt;
  logic [15:0]          len_q;
  logic [7:0]           spt_q, dpt_q;
  logic                 err_q;
  logic [31:0]          seed_q;
  logic [11:0]          beat_q, last_beat_q;
  logic [7:0]           gap_q;
  logic [31:0]          pkt_count_q;

  logic                 cmd_ready;
  logic                 tvalid;
  logic                 tlast;
  logic [DAT_BYTES-1:0] tstrb;
  logic                 is_last;
  logic                 accept;
  logic                 start;
  logic                 handshake;
  logic [31:0]          base_word;
  logic [DAT_W-1:0]     pattern;
  logic [DAT_W-1:0]     tdata;

  assign is_last   = (beat_q == last_beat_q);
  assign accept    = CMD_VALID & cmd_ready;
  assign start     = accept & (CMD_LEN != 16'd0);
  assign handshake = tvalid & M_AXIS.DAT_TREADY;

  // Next-state and handshake outputs, all derived from registered state.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would infer a latch.
    state_nxt = state;
    cmd_ready = 1'b0;
    tvalid    = 1'b0;
    tlast     = 1'b0;
    tstrb     = '0;
    unique case (state)
      IDLE: begin
        // Held low while reset is asserted so the reset value reads as zero.
        cmd_ready = ENABLE & ~ARESET;
        if (CMD_VALID && cmd_ready && CMD_LEN != 16'd0) state_nxt = SEND;
      end
      SEND: begin
        tvalid = 1'b1;
        tlast  = is_last;
        tstrb  = is_last ? last_strb(len_q[4:0]) : '1;
        if (M_AXIS.DAT_TREADY && is_last) state_nxt = (IFG_CNT != 8'd0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q <= 8'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments make every register update from the
    // values sampled at the same edge, independent of statement order.
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Command latch, beat/gap counters and completed-packet counter.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      len_q       <= '0;
      spt_q       <= '0;
      dpt_q       <= '0;
      err_q       <= 1'b0;
      seed_q      <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      gap_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      if (start) begin
        len_q       <= CMD_LEN;
        spt_q       <= CMD_SPT;
        dpt_q       <= CMD_DPT;
        err_q       <= CMD_ERR;
        seed_q      <= CMD_SEED;
        beat_q      <= '0;
        last_beat_q <= beats(CMD_LEN) - 12'd1;
      end
      if (handshake) begin
        beat_q <= beat_q + 12'd1;
        if (is_last) begin
          pkt_count_q <= pkt_count_q + 32'd1;
          gap_q       <= IFG_CNT;
        end
      end
      if (state == GAP) gap_q <= gap_q - 8'd1;
    end
  end

  // First word of the current beat: SEED + 8*beat.
  assign base_word = seed_q + {17'd0, beat_q, 3'd0};

  // Word k of the beat is base_word + k; bytes outside TSTRB read as zero,
  // which also zeroes TDATA whenever TVALID is low.
  for (genvar k = 0; k < DAT_W / 32; k++) begin : g_word
    assign pattern[32*k +: 32] = base_word + 32'(k);
  end

  for (genvar i = 0; i < DAT_BYTES; i++) begin : g_byte
    assign tdata[8*i +: 8] = tstrb[i] ? pattern[8*i +: 8] : 8'd0;
  end

  assign CMD_READY         = cmd_ready;
  assign M_AXIS.DAT_TDATA  = tdata;
  assign M_AXIS.DAT_TVALID = tvalid;
  assign M_AXIS.DAT_TSTRB  = tstrb;
  assign M_AXIS.DAT_TLAST  = tlast;
  assign M_AXIS.LEN_TDATA  = len_q;
  assign M_AXIS.SPT_TDATA  = spt_q;
  assign M_AXIS.DPT_TDATA  = dpt_q;
  assign M_AXIS.ERR_TDATA  = err_q;
  assign BUSY              = (state != IDLE);
  assign PKT_COUNT         = pkt_count_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: expected values are written out by hand or
// rebuilt from the word-pattern definition (SEED + 8*beat + k, masked by TSTRB).
module tb_axis_pkt_gen;

  localparam int IFG = 4;

  logic        clk = 1'b0;
  logic        areset;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_spt;
  logic [7:0]  cmd_dpt;
  logic        cmd_err;
  logic [31:0] cmd_seed;
  logic        busy;
  logic [31:0] pkt_count;

  axis_pkt_gen_if m_axis ();

  axis_pkt_gen #(.IFG(IFG)) dut (
    .ACLK      (clk),
    .ARESET    (areset),
    .ENABLE    (enable),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD_LEN   (cmd_len),
    .CMD_SPT   (cmd_spt),
    .CMD_DPT   (cmd_dpt),
    .CMD_ERR   (cmd_err),
    .CMD_SEED  (cmd_seed),
    .M_AXIS    (m_axis),
    .BUSY      (busy),
    .PKT_COUNT (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
    logic [15:0]  len;
    logic [7:0]   spt;
    logic [7:0]   dpt;
    logic         err;
    int           cyc;
  } beat_t;

  beat_t beats_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    exp_count = 0;

  // Cycle index, advanced on the active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat that will hand over on the coming rising edge.
  always @(negedge clk) begin
    if (m_axis.DAT_TVALID === 1'b1 && m_axis.DAT_TREADY === 1'b1)
      beats_q.push_back('{m_axis.DAT_TDATA, m_axis.DAT_TSTRB, m_axis.DAT_TLAST,
                          m_axis.LEN_TDATA, m_axis.SPT_TDATA, m_axis.DPT_TDATA,
                          m_axis.ERR_TDATA, cyc});
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] beat_data(input logic [31:0] seed, input int b,
                                             input logic [31:0] strb);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = seed + 32'(8 * b + k);
    for (int i = 0; i < 32; i++) if (!strb[i]) d[8*i +: 8] = 8'h00;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command and wait (bounded) for it to be taken; returns the accept cycle.
  task automatic send_cmd(input logic [15:0] len, input logic [7:0] spt, input logic [7:0] dpt,
                          input logic err, input logic [31:0] seed, output int acc);
    cmd_len   = len;
    cmd_spt   = spt;
    cmd_dpt   = dpt;
    cmd_err   = err;
    cmd_seed  = seed;
    cmd_valid = 1'b1;
    acc       = -1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      step();
    end
    check("cmd_accept", (acc >= 0), 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (beats_q.size() >= n) break;
      step();
    end
    check(tag, beats_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int start_cyc;
    int seen;
    int accepts;
    logic [255:0] snap_d;
    logic         snap_l;

    areset    = 1'b1;
    enable    = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_spt   = '0;
    cmd_dpt   = '0;
    cmd_err   = 1'b0;
    cmd_seed  = '0;
    m_axis.DAT_TREADY = 1'b1;

    // Reset values, with ENABLE already high.
    repeat (3) step();
    @(negedge clk);
    check("rst_tvalid", m_axis.DAT_TVALID, 0);
    check("rst_tlast", m_axis.DAT_TLAST, 0);
    check("rst_tstrb", m_axis.DAT_TSTRB, 0);
    check("rst_tdata", m_axis.DAT_TDATA, 0);
    check("rst_len", m_axis.LEN_TDATA, 0);
    check("rst_spt", m_axis.SPT_TDATA, 0);
    check("rst_err", m_axis.ERR_TDATA, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_count", pkt_count, 0);
    step();
    areset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);
    step();

    // Basic two-beat packet.
    beats_q.delete();
    send_cmd(16'd64, 8'd1, 8'd2, 1'b0, 32'd0, acc);
    wait_beats("t1_nbeats", 2, 20);
    exp_count = 1;
    if (beats_q.size() >= 2) begin
      check("t1_b0_data", beats_q[0].data,
            256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
      check("t1_b1_data", beats_q[1].data,
            256'h0000000F_0000000E_0000000D_0000000C_0000000B_0000000A_00000009_00000008);
      check("t1_b0_strb", beats_q[0].strb, 32'hFFFF_FFFF);
      check("t1_b1_strb", beats_q[1].strb, 32'hFFFF_FFFF);
      check("t1_b0_last", beats_q[0].last, 0);
      check("t1_b1_last", beats_q[1].last, 1);
      check("t1_b0_cyc", beats_q[0].cyc, acc + 1);
      check("t1_b1_cyc", beats_q[1].cyc, acc + 2);
      check("t1_len", beats_q[1].len, 64);
      check("t1_spt", beats_q[0].spt, 1);
      check("t1_dpt", beats_q[0].dpt, 2);
    end
    check("t1_pkt_count", pkt_count, exp_count);

    // Partial final beat, error flag carried on the sideband.
    beats_q.delete();
    send_cmd(16'd33, 8'd3, 8'd4, 1'b1, 32'd0, acc);
    wait_beats("t2_nbeats", 2, 30);
    exp_count = 2;
    if (beats_q.size() >= 2) begin
      check("t2_b0_strb", beats_q[0].strb, 32'hFFFF_FFFF);
      check("t2_b0_last", beats_q[0].last, 0);
      check("t2_b1_strb", beats_q[1].strb, 32'h0000_0001);
      check("t2_b1_data", beats_q[1].data, 256'h08);
      check("t2_b1_last", beats_q[1].last, 1);
      check("t2_err", beats_q[1].err, 1);
      check("t2_len", beats_q[1].len, 33);
    end
    check("t2_pkt_count", pkt_count, exp_count);

    // Backpressure: TREADY toggles every cycle starting low.
    beats_q.delete();
    m_axis.DAT_TREADY = 1'b0;
    send_cmd(16'd96, 8'd5, 8'd6, 1'b0, 32'h100, acc);
    for (int i = 0; i < 10; i++) begin
      m_axis.DAT_TREADY = (i % 2 == 1);
      @(negedge clk);
      if (i < 6) begin
        if (i % 2 == 0) begin
          check("bp_stall_valid", m_axis.DAT_TVALID, 1);
          snap_d = m_axis.DAT_TDATA;
          snap_l = m_axis.DAT_TLAST;
        end else begin
          check("bp_hold_valid", m_axis.DAT_TVALID, 1);
          check("bp_hold_data", m_axis.DAT_TDATA, snap_d);
          check("bp_hold_last", m_axis.DAT_TLAST, snap_l);
        end
      end
      step();
    end
    m_axis.DAT_TREADY = 1'b1;
    exp_count = 3;
    check("bp_nbeats", beats_q.size(), 3);
    if (beats_q.size() == 3) begin
      for (int b = 0; b < 3; b++) begin
        check("bp_data", beats_q[b].data, beat_data(32'h100, b, 32'hFFFF_FFFF));
        check("bp_last", beats_q[b].last, (b == 2));
      end
    end
    check("bp_pkt_count", pkt_count, exp_count);

    // Back-to-back single-beat packets with CMD_VALID held high.
    beats_q.delete();
    cmd_len   = 16'd32;
    cmd_spt   = 8'd7;
    cmd_dpt   = 8'd8;
    cmd_err   = 1'b0;
    cmd_seed  = 32'h2000;
    cmd_valid = 1'b1;
    accepts   = 0;
    for (int i = 0; i < 40 && accepts < 2; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) accepts++;
      step();
      if (accepts == 1) cmd_seed = 32'h3000;
      if (accepts == 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    check("b2b_accepts", accepts, 2);
    wait_beats("b2b_nbeats", 2, 30);
    exp_count = 5;
    if (beats_q.size() >= 2) begin
      check("b2b_spacing", beats_q[1].cyc - beats_q[0].cyc, IFG + 2);
      check("b2b_last0", beats_q[0].last, 1);
      check("b2b_last1", beats_q[1].last, 1);
      check("b2b_data0", beats_q[0].data, beat_data(32'h2000, 0, 32'hFFFF_FFFF));
      check("b2b_data1", beats_q[1].data, beat_data(32'h3000, 0, 32'hFFFF_FFFF));
    end
    check("b2b_pkt_count", pkt_count, exp_count);

    // Zero-length command: consumed immediately, nothing emitted.
    repeat (IFG + 1) step();
    beats_q.delete();
    start_cyc = cyc;
    send_cmd(16'd0, 8'd0, 8'd0, 1'b0, 32'h99, acc);
    check("zero_accept_cyc", acc, start_cyc);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_axis.DAT_TVALID !== 1'b0) seen++;
      step();
    end
    check("zero_no_tvalid", seen, 0);
    check("zero_busy", busy, 0);
    check("zero_pkt_count", pkt_count, exp_count);

    // ENABLE low holds off a pending command.
    enable    = 1'b0;
    cmd_len   = 16'd32;
    cmd_seed  = 32'h55;
    cmd_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0) seen++;
      step();
    end
    check("en_ready_low", seen, 0);
    check("en_no_beats", beats_q.size(), 0);
    enable = 1'b1;
    start_cyc = cyc;
    send_cmd(16'd32, 8'd9, 8'd10, 1'b0, 32'h55, acc);
    check("en_accept_cyc", acc, start_cyc);
    wait_beats("en_nbeats", 1, 10);
    exp_count = 6;
    if (beats_q.size() >= 1) check("en_data", beats_q[0].data, beat_data(32'h55, 0, 32'hFFFF_FFFF));

    // Seed wrap across the 32-bit boundary.
    beats_q.delete();
    send_cmd(16'd64, 8'd1, 8'd1, 1'b0, 32'hFFFF_FFFC, acc);
    wait_beats("wrap_nbeats", 2, 30);
    exp_count = 7;
    if (beats_q.size() >= 2) begin
      check("wrap_b0", beats_q[0].data,
            256'h00000003_00000002_00000001_00000000_FFFFFFFF_FFFFFFFE_FFFFFFFD_FFFFFFFC);
      check("wrap_b1", beats_q[1].data,
            256'h0000000B_0000000A_00000009_00000008_00000007_00000006_00000005_00000004);
    end
    check("wrap_pkt_count", pkt_count, exp_count);

    // Reset during beat 3 of an 8-beat packet.
    beats_q.delete();
    send_cmd(16'd256, 8'd2, 8'd3, 1'b1, 32'h1000, acc);
    repeat (3) step();
    areset = 1'b1;
    @(negedge clk);
    check("mrst_beat3", m_axis.DAT_TDATA, beat_data(32'h1000, 3, 32'hFFFF_FFFF));
    check("mrst_busy", busy, 1);
    step();
    @(negedge clk);
    exp_count = 0;
    check("mrst_tvalid", m_axis.DAT_TVALID, 0);
    check("mrst_tlast", m_axis.DAT_TLAST, 0);
    check("mrst_tdata", m_axis.DAT_TDATA, 0);
    check("mrst_len", m_axis.LEN_TDATA, 0);
    check("mrst_busy_low", busy, 0);
    check("mrst_pkt_count", pkt_count, exp_count);
    step();
    areset = 1'b0;
    beats_q.delete();
    send_cmd(16'd64, 8'd4, 8'd5, 1'b0, 32'hABCD_0000, acc);
    wait_beats("post_nbeats", 2, 20);
    exp_count = 1;
    if (beats_q.size() >= 2) begin
      check("post_b0_cyc", beats_q[0].cyc, acc + 1);
      check("post_b0_data", beats_q[0].data, beat_data(32'hABCD_0000, 0, 32'hFFFF_FFFF));
      check("post_b1_last", beats_q[1].last, 1);
    end
    check("post_pkt_count", pkt_count, exp_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
